frame_checker: RTL and testbench
================================

# frame_checker

Receive-side counterpart of the frame generator. Consumes 16-bit AXI-Stream Ethernet-style frames on an ingress port: preamble/SFD, destination MAC, source MAC, length, type, payload. Checks framing, computes a 32-bit payload byte checksum, and publishes the last good header, the checksum and the good/error frame counts over an 8-bit Avalon-MM slave. Sits at the egress end of the packet-filter datapath as a loopback/self-test sink.

## Interface
Parameters:
- MAX_LEN, 1500, largest accepted payload length in bytes; larger lengths are length errors.

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- writedata  in  8  Avalon write data
- write  in  1  Avalon write strobe
- chipselect  in  1  Avalon select
- address  in  8  Avalon byte address
- read  in  1  Avalon read strobe
- readdata  out  8  Avalon read data, registered
- ingress_port_tdata  in  16  stream data; tdata[15:8] is the earlier byte on the wire
- ingress_port_tlast  in  1  last beat of frame
- ingress_port_tvalid  in  1  beat valid
- ingress_port_tready  out  1  checker ready

## Operation
- Beat = tvalid && tready. Frame layout in beats:
  - 0–2: 0xAAAA.
  - 3: 0xAAAB.
  - 4–6: dst MAC, bytes 0..5, high byte first.
  - 7–9: src MAC.
  - 10: length word; len = {tdata[7:0], tdata[15:8]}.
  - 11: type word; type byte0 = tdata[15:8].
  - 12 onward: payload, ceil(len/2) beats.
- tlast is required exactly on beat 11+ceil(len/2). For len=0, that is beat 11.
- States:
  - IDLE: waiting for beat 0.
  - PREAMBLE: beats 0–3.
  - HEADER: beats 4–11.
  - PAYLOAD: payload beats.
  - DRAIN: discard beats until tlast.
  - COMMIT: one cycle, tready=0.
- Error codes (3 bits):
  - 1 = preamble/SFD mismatch.
  - 2 = tlast early (before the expected beat).
  - 3 = tlast missing on the expected beat.
  - 4 = len > MAX_LEN, detected on beat 10.
  - 5 = filtered (see Configuration).
- First error on an accepted beat latches its code.
  - If that beat carries tlast, go to COMMIT.
  - Otherwise go to DRAIN, then COMMIT on the tlast beat.
- Checksum: 32-bit running sum, wrapping, of payload bytes tdata[15:8] + tdata[7:0] per beat. On an odd len the final beat adds only tdata[15:8]. The sum is cleared on entering PREAMBLE.
- Header bytes are captured into shadow registers. In COMMIT:
  - Good frame: copy shadows and checksum to the visible registers, good_cnt+1.
  - Bad frame: err_cnt+1, last_err updated; visible header/checksum left unchanged.
- Counters are 8 bits and saturate at 255.
- Register map (R = read, W = write):
  - 0–5 R: dst MAC. 6–11 R: src MAC. 12/13 R: len lo/hi. 14/15 R: type bytes.
  - 16 R: good_cnt. 17 R: err_cnt.
  - 18 R: status = {4'b0, busy, last_err[2:0]}; busy = state ≠ IDLE.
  - 19–22 R: checksum bytes 0–3.
  - 23 W: control; bit0 = clear counters and last_err, self-clearing.
  - Unmapped reads return 0. Writes to read-only addresses are ignored.

## Timing
- Reset values:
  - readdata = 0, tready = 0, state IDLE.
  - All visible registers, counters and checksum = 0.
  - tready rises on the first cycle after reset deasserts.
- tready is 1 in every state except COMMIT and during reset. The checker never stalls otherwise.
- Results become readable on the cycle after COMMIT. Read latency is 1 cycle. readdata = 0 when chipselect&&read is low.
- Simultaneous clear write and COMMIT: clear wins, counters end at 0.
- Reset mid-frame: return to IDLE, discard shadows.
  - Stale beats arriving after reset hit error 1 at IDLE and are drained to tlast.
  - A lone bad tlast beat at IDLE is counted as an error frame.
- Tvalid low mid-frame pauses all state; no timeout.

## Configuration
- FRAME_CHECKER_DST_FILTER_EN defined:
  - Adds W/R registers 24–29 holding the filter MAC, reset 00:00:00:00:00:00.
  - A frame whose dst is neither the filter MAC nor FF:FF:FF:FF:FF:FF gets error 5 at beat 6, then drains.
- Undefined:
  - Addresses 24–29 read 0 and ignore writes.
  - Every dst is accepted; code 5 never occurs.

## Test plan
- Frame with dst 01..06, src 11..16, len=4, type 0x0800, payload 0x0102,0x0304 -> good_cnt=1, checksum reads 0x0A,0,0,0, address 12 reads 0x04, status=0.
- len=0 frame with tlast on the type beat -> good_cnt=1, checksum=0. Same frame with tlast missing -> err_cnt=1, last_err=3.
- Word 3 = 0xAAAA instead of 0xAAAB, 20 beats then tlast -> err_cnt=1, last_err=1, visible header unchanged, tready low exactly one cycle after tlast.
- len=3, payload beats 0xFF10,0x2099 -> checksum = 0xFF+0x10+0x20 = 0x12F.
- 256 good frames, then a write of 0x01 to address 23 coincident with a COMMIT -> good_cnt reads 255 before the write and 0 after.
- With FRAME_CHECKER_DST_FILTER_EN and filter MAC 01..06: a frame to 0A..0F gives last_err=5; a broadcast frame gives good_cnt+1.

Source files
------------

// File: rtl/frame_checker_if.sv
// rtl/frame_checker_if.sv - Avalon-MM register port and ingress stream bundle for frame_checker
interface frame_checker_if;
    logic [7:0]  writedata;
    logic        write;
    logic        chipselect;
    logic [7:0]  address;
    logic        read;
    logic [7:0]  readdata;
    logic [15:0] ingress_port_tdata;
    logic        ingress_port_tlast;
    logic        ingress_port_tvalid;
    logic        ingress_port_tready;

    modport slave (
        input  writedata, write, chipselect, address, read,
        input  ingress_port_tdata, ingress_port_tlast, ingress_port_tvalid,
        output readdata, ingress_port_tready
    );

    modport master (
        output writedata, write, chipselect, address, read,
        output ingress_port_tdata, ingress_port_tlast, ingress_port_tvalid,
        input  readdata, ingress_port_tready
    );
endinterface

// File: rtl/frame_checker.sv
// rtl/frame_checker.sv - ingress frame checker with header/checksum/count registers
// Optional destination MAC filter enabled by FRAME_CHECKER_DST_FILTER_EN.
module frame_checker #(
    parameter int MAX_LEN = 1500
) (
    input  logic           clk,
    input  logic           reset,
    frame_checker_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DRAIN, COMMIT} state_t;

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    state_t      state, state_nxt;
    logic        tready;
    logic [3:0]  beat_idx;
    logic [15:0] pay_left;
    logic [2:0]  err_code, err_now;
    logic [47:0] sh_dst, sh_src, vis_dst, vis_src;
    logic [15:0] sh_len, sh_type, vis_len, vis_type;
    logic [31:0] sum, vis_sum;
    logic [7:0]  good_cnt, err_cnt, rd_mux, rd_q;
    logic [2:0]  last_err;
    logic        beat, tlast, wr, clr, filt_err;
    logic [15:0] tdata, len_word;
    logic [16:0] len_p1;

    assign tdata    = bus.ingress_port_tdata;
    assign tlast    = bus.ingress_port_tlast;
    assign beat     = bus.ingress_port_tvalid && tready;
    assign len_word = {tdata[7:0], tdata[15:8]};
    assign len_p1   = {1'b0, sh_len} + 17'd1;
    assign wr       = bus.chipselect && bus.write;
    assign clr      = wr && (bus.address == 8'd23) && bus.writedata[0];
    assign bus.ingress_port_tready = tready;
    assign bus.readdata            = rd_q;

`ifdef FRAME_CHECKER_DST_FILTER_EN
    logic [47:0] filt_mac, dst_full;
    assign dst_full = {sh_dst[47:16], tdata};
    assign filt_err = (state == HEADER) && (beat_idx == 4'd6) &&
                      (dst_full != filt_mac) && (dst_full != 48'hFFFF_FFFF_FFFF);
`else
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[7:1];
    assign filt_err     = 1'b0;
`endif

    // Content errors (1/4/5) outrank tlast placement errors on the same beat.
    always_comb begin
        err_now = 3'd0;
        case (state)
            IDLE: begin
                if (tdata != 16'hAAAA)  err_now = 3'd1;
                else if (tlast)         err_now = 3'd2;
            end
            PREAMBLE: begin
                if (tdata != ((beat_idx == 4'd3) ? 16'hAAAB : 16'hAAAA)) err_now = 3'd1;
                else if (tlast)                                          err_now = 3'd2;
            end
            HEADER: begin
                if (beat_idx == 4'd10 && len_word > MAX_LEN_W) err_now = 3'd4;
                else if (filt_err)                             err_now = 3'd5;
                else if (beat_idx == 4'd11) begin
                    if (sh_len == 16'd0 && !tlast)      err_now = 3'd3;
                    else if (sh_len != 16'd0 && tlast)  err_now = 3'd2;
                end else if (tlast)                     err_now = 3'd2;
            end
            PAYLOAD: begin
                if (pay_left == 16'd1 && !tlast)       err_now = 3'd3;
                else if (pay_left != 16'd1 && tlast)   err_now = 3'd2;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, PREAMBLE, HEADER, PAYLOAD: begin
                if (beat) begin
                    if (err_now != 3'd0)  state_nxt = tlast ? COMMIT : DRAIN;
                    else if (tlast)       state_nxt = COMMIT;
                    else if (state == IDLE) state_nxt = PREAMBLE;
                    else if (state == PREAMBLE && beat_idx == 4'd3) state_nxt = HEADER;
                    else if (state == HEADER && beat_idx == 4'd11)  state_nxt = PAYLOAD;
                end
            end
            DRAIN:   if (beat && tlast) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            tready <= 1'b0;
        end else begin
            state  <= state_nxt;
            tready <= (state_nxt != COMMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_idx <= '0; pay_left <= '0; err_code <= '0; sum <= '0;
            sh_dst <= '0; sh_src <= '0; sh_len <= '0; sh_type <= '0;
            vis_dst <= '0; vis_src <= '0; vis_len <= '0; vis_type <= '0; vis_sum <= '0;
            good_cnt <= '0; err_cnt <= '0; last_err <= '0;
`ifdef FRAME_CHECKER_DST_FILTER_EN
            filt_mac <= '0;
`endif
        end else begin
            if (beat) begin
                case (state)
                    IDLE: begin
                        beat_idx <= 4'd1;
                        sum      <= '0;
                        err_code <= err_now;
                    end
                    PREAMBLE: begin
                        beat_idx <= beat_idx + 4'd1;
                        if (err_now != 3'd0) err_code <= err_now;
                    end
                    HEADER: begin
                        beat_idx <= beat_idx + 4'd1;
                        if (err_now != 3'd0) err_code <= err_now;
                        case (beat_idx)
                            4'd4:  sh_dst[47:32] <= tdata;
                            4'd5:  sh_dst[31:16] <= tdata;
                            4'd6:  sh_dst[15:0]  <= tdata;
                            4'd7:  sh_src[47:32] <= tdata;
                            4'd8:  sh_src[31:16] <= tdata;
                            4'd9:  sh_src[15:0]  <= tdata;
                            4'd10: sh_len        <= len_word;
                            4'd11: begin
                                sh_type  <= tdata;
                                pay_left <= len_p1[16:1];
                            end
                            default: ;
                        endcase
                    end
                    PAYLOAD: begin
                        pay_left <= pay_left - 16'd1;
                        if (err_now != 3'd0) err_code <= err_now;
                        // An odd length leaves the low byte of the final beat as padding.
                        sum <= sum + {24'd0, tdata[15:8]} +
                               ((pay_left == 16'd1 && sh_len[0]) ? 32'd0 : {24'd0, tdata[7:0]});
                    end
                    default: ;
                endcase
            end
            if (state == COMMIT) begin
                err_code <= 3'd0;
                if (err_code == 3'd0) begin
                    vis_dst <= sh_dst; vis_src <= sh_src; vis_len <= sh_len;
                    vis_type <= sh_type; vis_sum <= sum;
                    if (good_cnt != 8'hFF) good_cnt <= good_cnt + 8'd1;
                end else begin
                    last_err <= err_code;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
            end
            if (clr) begin
                good_cnt <= '0; err_cnt <= '0; last_err <= '0;
            end
`ifdef FRAME_CHECKER_DST_FILTER_EN
            if (wr) begin
                case (bus.address)
                    8'd24: filt_mac[47:40] <= bus.writedata;
                    8'd25: filt_mac[39:32] <= bus.writedata;
                    8'd26: filt_mac[31:24] <= bus.writedata;
                    8'd27: filt_mac[23:16] <= bus.writedata;
                    8'd28: filt_mac[15:8]  <= bus.writedata;
                    8'd29: filt_mac[7:0]   <= bus.writedata;
                    default: ;
                endcase
            end
`endif
        end
    end

    always_comb begin
        rd_mux = 8'd0;
        case (bus.address)
            8'd0:  rd_mux = vis_dst[47:40];
            8'd1:  rd_mux = vis_dst[39:32];
            8'd2:  rd_mux = vis_dst[31:24];
            8'd3:  rd_mux = vis_dst[23:16];
            8'd4:  rd_mux = vis_dst[15:8];
            8'd5:  rd_mux = vis_dst[7:0];
            8'd6:  rd_mux = vis_src[47:40];
            8'd7:  rd_mux = vis_src[39:32];
            8'd8:  rd_mux = vis_src[31:24];
            8'd9:  rd_mux = vis_src[23:16];
            8'd10: rd_mux = vis_src[15:8];
            8'd11: rd_mux = vis_src[7:0];
            8'd12: rd_mux = vis_len[7:0];
            8'd13: rd_mux = vis_len[15:8];
            8'd14: rd_mux = vis_type[15:8];
            8'd15: rd_mux = vis_type[7:0];
            8'd16: rd_mux = good_cnt;
            8'd17: rd_mux = err_cnt;
            8'd18: rd_mux = {4'b0, state != IDLE, last_err};
            8'd19: rd_mux = vis_sum[7:0];
            8'd20: rd_mux = vis_sum[15:8];
            8'd21: rd_mux = vis_sum[23:16];
            8'd22: rd_mux = vis_sum[31:24];
`ifdef FRAME_CHECKER_DST_FILTER_EN
            8'd24: rd_mux = filt_mac[47:40];
            8'd25: rd_mux = filt_mac[39:32];
            8'd26: rd_mux = filt_mac[31:24];
            8'd27: rd_mux = filt_mac[23:16];
            8'd28: rd_mux = filt_mac[15:8];
            8'd29: rd_mux = filt_mac[7:0];
`endif
            default: rd_mux = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) rd_q <= 8'd0;
        else       rd_q <= (bus.chipselect && bus.read) ? rd_mux : 8'd0;
    end
endmodule

// File: tb/tb_frame_checker.sv
// tb/tb_frame_checker.sv - directed table-driven bench for frame_checker
module tb_frame_checker;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    frame_checker_if bus();
    frame_checker #(.MAX_LEN(1500)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] src;
        logic [15:0] len;
        logic [15:0] typ;
        int          mode;   // 0 good, 1 bad SFD, 2 tlast missing, 3 tlast early, 4 len too big
        bit          gap;
        logic [31:0] sum;
        logic [2:0]  err;
    } vec_t;

    vec_t        tbl[8];
    logic [15:0] pay_q[$];
    logic [47:0] dst_main = 48'h0102_0304_0506;
    logic [7:0]  rdv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
        @(posedge clk); #1;
        d = bus.readdata;
        bus.chipselect = 1'b0; bus.read = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        chk(name, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic put_beat(input logic [15:0] d, input logic l);
        int n = 0;
        bus.ingress_port_tdata  = d;
        bus.ingress_port_tlast  = l;
        bus.ingress_port_tvalid = 1'b1;
        while (!bus.ingress_port_tready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL tready_wait: got tready=0 for %0d cycles expected 1", n);
        end
        @(posedge clk); #1;
        bus.ingress_port_tvalid = 1'b0;
        bus.ingress_port_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] len,
                              input logic [15:0] typ, input int mode, input bit gap, input bit clr);
        logic [15:0] w[$];
        int last_i;
        w = {};
        for (int i = 0; i < 3; i++) w.push_back(16'hAAAA);
        w.push_back((mode == 1) ? 16'hAAAA : 16'hAAAB);
        if (mode == 1) begin
            for (int i = 4; i < 20; i++) w.push_back(16'h5A5A);
        end else begin
            w.push_back(dst[47:32]); w.push_back(dst[31:16]); w.push_back(dst[15:0]);
            w.push_back(src[47:32]); w.push_back(src[31:16]); w.push_back(src[15:0]);
            w.push_back({len[7:0], len[15:8]});
            if (mode == 4) begin
                for (int i = 0; i < 3; i++) w.push_back(16'hC3C3);
            end else begin
                w.push_back(typ);
                while (pay_q.size() > 0) w.push_back(pay_q.pop_front());
                if (mode == 2) w.push_back(16'h0000);
            end
        end
        pay_q = {};
        last_i = (mode == 3) ? 12 : w.size() - 1;
        for (int i = 0; i <= last_i; i++) begin
            if (gap && (i % 3 == 1)) begin
                @(posedge clk); #1;
            end
            put_beat(w[i], i == last_i);
        end
        if (clr) begin
            bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 8'd23; bus.writedata = 8'h01;
        end
        chk("commit_tready_low", {31'd0, bus.ingress_port_tready}, 32'd0);
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write = 1'b0;
        chk("post_commit_tready_high", {31'd0, bus.ingress_port_tready}, 32'd1);
    endtask

    int          exp_good = 0, exp_err = 0;
    logic [2:0]  exp_last = 3'd0;
    logic [7:0]  exp_src0 = 8'd0, exp_len_lo = 8'd0;
    logic [31:0] exp_sum = 32'd0;

    initial begin
        tbl[0] = '{48'h1112_1314_1516, 16'd4,    16'h0800, 0, 1'b0, 32'h0A,  3'd0};
        tbl[1] = '{48'h2122_2324_2526, 16'd0,    16'h0806, 0, 1'b0, 32'h00,  3'd0};
        tbl[2] = '{48'h3132_3334_3536, 16'd0,    16'h0800, 2, 1'b0, 32'h00,  3'd3};
        tbl[3] = '{48'h4142_4344_4546, 16'd4,    16'h0800, 1, 1'b0, 32'h00,  3'd1};
        tbl[4] = '{48'h5152_5354_5556, 16'd5,    16'h86DD, 0, 1'b1, 32'h0F,  3'd0};
        tbl[5] = '{48'h6162_6364_6566, 16'd1501, 16'h0800, 4, 1'b0, 32'h00,  3'd4};
        tbl[6] = '{48'h7172_7374_7576, 16'd4,    16'h0800, 3, 1'b0, 32'h00,  3'd2};
        tbl[7] = '{48'h8182_8384_8586, 16'd40,   16'h0800, 0, 1'b1, 32'h334, 3'd0};

        bus.writedata = 8'd0; bus.write = 1'b0; bus.chipselect = 1'b0; bus.address = 8'd0;
        bus.read = 1'b0; bus.ingress_port_tdata = 16'd0; bus.ingress_port_tlast = 1'b0;
        bus.ingress_port_tvalid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tready", {31'd0, bus.ingress_port_tready}, 32'd0);
        chk("reset_readdata", {24'd0, bus.readdata}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("tready_after_reset", {31'd0, bus.ingress_port_tready}, 32'd1);
        chk_rd("reset_status", 8'd18, 8'd0);
        chk_rd("reset_good", 8'd16, 8'd0);
        chk_rd("reset_sum0", 8'd19, 8'd0);
        chk_rd("reset_dst0", 8'd0, 8'd0);

`ifdef FRAME_CHECKER_DST_FILTER_EN
        for (int i = 0; i < 6; i++) wr(8'(24 + i), 8'(i + 1));
        chk_rd("filt_rd24", 8'd24, 8'h01);
        chk_rd("filt_rd29", 8'd29, 8'h06);
`endif

        for (int t = 0; t < 8; t++) begin
            if (tbl[t].mode == 0 || tbl[t].mode == 2 || tbl[t].mode == 3)
                for (int k = 0; k < (int'(tbl[t].len) + 1) / 2; k++)
                    pay_q.push_back({8'(2 * k + 1), 8'(2 * k + 2)});
            send_frame(dst_main, tbl[t].src, tbl[t].len, tbl[t].typ, tbl[t].mode, tbl[t].gap, 1'b0);
            if (tbl[t].err == 3'd0) begin
                exp_good++;
                exp_src0   = tbl[t].src[47:40];
                exp_len_lo = tbl[t].len[7:0];
                exp_sum    = tbl[t].sum;
            end else begin
                exp_err++;
                exp_last = tbl[t].err;
            end
            chk_rd($sformatf("v%0d_good", t), 8'd16, 8'(exp_good));
            chk_rd($sformatf("v%0d_err", t), 8'd17, 8'(exp_err));
            chk_rd($sformatf("v%0d_status", t), 8'd18, {5'd0, exp_last});
            chk_rd($sformatf("v%0d_src0", t), 8'd6, exp_src0);
            chk_rd($sformatf("v%0d_len_lo", t), 8'd12, exp_len_lo);
            chk_rd($sformatf("v%0d_sum0", t), 8'd19, exp_sum[7:0]);
            chk_rd($sformatf("v%0d_sum1", t), 8'd20, exp_sum[15:8]);
        end

        pay_q = {16'hFF10, 16'h2099};
        send_frame(dst_main, 48'h9192_9394_9596, 16'd3, 16'h0800, 0, 1'b0, 1'b0);
        chk_rd("odd_sum0", 8'd19, 8'h2F);
        chk_rd("odd_sum1", 8'd20, 8'h01);
        chk_rd("odd_len_lo", 8'd12, 8'h03);
        chk_rd("odd_src0", 8'd6, 8'h91);
        chk_rd("odd_type0", 8'd14, 8'h08);

        // Reset in the middle of a frame, then the stale tail arrives.
        for (int i = 0; i < 3; i++) put_beat(16'hAAAA, 1'b0);
        put_beat(16'hAAAB, 1'b0);
        put_beat(16'h0102, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset_tready_low", {31'd0, bus.ingress_port_tready}, 32'd0);
        put_beat(16'h1234, 1'b0);
        put_beat(16'h1234, 1'b0);
        put_beat(16'h1234, 1'b1);
        @(posedge clk); #1;
        chk_rd("stale_err", 8'd17, 8'd1);
        chk_rd("stale_good", 8'd16, 8'd0);
        chk_rd("stale_status", 8'd18, 8'h01);
        chk_rd("stale_src0", 8'd6, 8'd0);

        put_beat(16'h5555, 1'b1);
        @(posedge clk); #1;
        chk_rd("lone_err", 8'd17, 8'd2);
        chk_rd("lone_status", 8'd18, 8'h01);

        for (int i = 0; i < 256; i++)
            send_frame(dst_main, 48'hA1A2_A3A4_A5A6, 16'd0, 16'h0800, 0, 1'b0, 1'b0);
        chk_rd("sat_good", 8'd16, 8'd255);
        send_frame(dst_main, 48'hA1A2_A3A4_A5A6, 16'd0, 16'h0800, 0, 1'b0, 1'b1);
        chk_rd("clr_good", 8'd16, 8'd0);
        chk_rd("clr_err", 8'd17, 8'd0);
        chk_rd("clr_status", 8'd18, 8'd0);

`ifdef FRAME_CHECKER_DST_FILTER_EN
        send_frame(48'h0A0B_0C0D_0E0F, 48'hB1B2_B3B4_B5B6, 16'd0, 16'h0800, 0, 1'b0, 1'b0);
        chk_rd("filt_status", 8'd18, 8'h05);
        chk_rd("filt_err", 8'd17, 8'd1);
        send_frame(48'hFFFF_FFFF_FFFF, 48'hC1C2_C3C4_C5C6, 16'd0, 16'h0800, 0, 1'b0, 1'b0);
        chk_rd("bcast_good", 8'd16, 8'd1);
`else
        wr(8'd24, 8'h55);
        chk_rd("nofilt_rd24", 8'd24, 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
